// File: rtl/keccak_squeeze_ctrl_if.sv
// Output word stream of the Keccak squeeze sequencer.
// One 64-bit byte-ordered word per valid/ready handshake, with a byte-valid
// mask and a flag marking the final word of the squeeze.
interface keccak_squeeze_ctrl_if;
    logic [63:0] o_data;
    logic [7:0]  o_keep;
    logic        o_last;
    logic        o_valid;
    logic        i_ready;

    modport master (
        output o_data,
        output o_keep,
        output o_last,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_keep,
        input  o_last,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/keccak_squeeze_ctrl.sv
// Keccak squeeze-phase sequencer.
// Walks the rate lanes of the state in order, byte-swaps each lane into
// little-endian output order (store64) and streams the words out, requesting
// a permutation whenever the rate portion is used up and more bytes remain.
// Optional build macro: KECCAK_SQZ_INITPERM_EN -- when defined, every
// non-empty squeeze starts with a permutation before the first lane read.
module keccak_squeeze_ctrl #(
    parameter  int BW_DATA = 64,
    parameter  int NLANE   = 25,
    localparam int AW      = $clog2(NLANE),
    localparam int NB      = BW_DATA / 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [4:0]         i_rate,
    input  logic [15:0]        i_nbytes,
    output logic               o_busy,
    output logic               o_lane_rd,
    output logic [AW-1:0]      o_lane_addr,
    input  logic [BW_DATA-1:0] i_lane_data,
    output logic               o_perm_start,
    input  logic               i_perm_done,
    output logic               o_done,
    keccak_squeeze_ctrl_if.master m_out
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        OUT,
        PERM,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_lane;
    logic [AW-1:0]       r_rate;
    logic [15:0]         r_remain;
    logic                r_permSent;
    logic [4:0]          w_rateClamp;
    logic                w_lastLane;
    logic [BW_DATA-1:0]  w_swapped;
    logic [BW_DATA-1:0]  w_masked;
    logic [NB-1:0]       w_keep;

    // Byte k of the lane (bits 8k+7:8k) lands in the k-th byte from the top.
    function automatic logic [BW_DATA-1:0] store64(input logic [BW_DATA-1:0] lane);
        logic [BW_DATA-1:0] swapped;
        swapped = '0;
        for (int k = 0; k < NB; k++) begin
            swapped[BW_DATA-1-8*k -: 8] = lane[8*k +: 8];
        end
        return swapped;
    endfunction

    assign w_rateClamp = ((i_rate == 5'd0) || (i_rate > 5'd21)) ? 5'd21 : i_rate;
    assign w_lastLane  = (r_lane == (r_rate - AW'(1)));
    assign w_swapped   = store64(i_lane_data);

    // Byte-valid mask from the remaining count; bytes past the end are zeroed.
    always_comb begin
        w_keep   = '0;
        w_masked = '0;
        for (int k = 0; k < NB; k++) begin
            if (16'(k) < r_remain) begin
                w_keep[k] = 1'b1;
                w_masked[BW_DATA-1-8*k -: 8] = w_swapped[BW_DATA-1-8*k -: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only looked at in IDLE so a busy start is ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_nbytes == 16'd0) begin
                        w_next = DONE;
                    end else begin
`ifdef KECCAK_SQZ_INITPERM_EN
                        w_next = PERM;
`else
                        w_next = READ;
`endif
                    end
                end
            end
            READ: w_next = CAPT;
            CAPT: w_next = OUT;
            OUT: begin
                if (m_out.i_ready) begin
                    if (m_out.o_last) begin
                        w_next = DONE;
                    end else if (w_lastLane) begin
                        w_next = PERM;
                    end else begin
                        w_next = READ;
                    end
                end
            end
            PERM: begin
                if (i_perm_done) begin
                    w_next = READ;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        o_busy        = (r_state != IDLE);
        o_lane_rd     = (r_state == READ);
        o_lane_addr   = (r_state == READ) ? r_lane : '0;
        o_perm_start  = (r_state == PERM) && !r_permSent;
        m_out.o_valid = (r_state == OUT);
        o_done        = (r_state == DONE);
    end

    // Datapath: rate/byte counter/lane index bookkeeping and the output word register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lane       <= '0;
            r_rate       <= '0;
            r_remain     <= '0;
            r_permSent   <= 1'b0;
            m_out.o_data <= '0;
            m_out.o_keep <= '0;
            m_out.o_last <= 1'b0;
        end else begin
            r_permSent <= (r_state == PERM);
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_rate   <= AW'(w_rateClamp);
                        r_remain <= i_nbytes;
                        r_lane   <= '0;
                    end
                end
                CAPT: begin
                    m_out.o_data <= w_masked;
                    m_out.o_keep <= w_keep;
                    m_out.o_last <= (r_remain <= 16'd8);
                end
                OUT: begin
                    if (m_out.i_ready) begin
                        r_remain <= (r_remain > 16'd8) ? (r_remain - 16'd8) : 16'd0;
                        if (!m_out.o_last) begin
                            r_lane <= w_lastLane ? '0 : (r_lane + AW'(1));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_ctrl.sv
// Self-checking bench for keccak_squeeze_ctrl.
// Lane k of the modelled state holds bytes 8k..8k+7 (lane byte j = 8k+j), so
// the expected output stream is simply the lane's byte numbers in order.
module tb_keccak_squeeze_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [4:0]  i_rate;
    logic [15:0] i_nbytes;
    logic        o_busy;
    logic        o_lane_rd;
    logic [4:0]  o_lane_addr;
    logic [63:0] i_lane_data;
    logic        o_perm_start;
    logic        i_perm_done;
    logic        o_done;

    keccak_squeeze_ctrl_if sqz ();

    keccak_squeeze_ctrl u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_rate       (i_rate),
        .i_nbytes     (i_nbytes),
        .o_busy       (o_busy),
        .o_lane_rd    (o_lane_rd),
        .o_lane_addr  (o_lane_addr),
        .i_lane_data  (i_lane_data),
        .o_perm_start (o_perm_start),
        .i_perm_done  (i_perm_done),
        .o_done       (o_done),
        .m_out        (sqz)
    );

    typedef struct {
        logic [4:0]  rate;
        logic [15:0] nbytes;
        int          readyMode;
        int          permDelay;
        int          midStart;
        int          effRate;
        int          expWords;
        int          expPerms;
        logic [7:0]  expLastKeep;
    } vec_t;

    int          errCount;
    int          checkCount;
    int          permCount;
    int          doneCount;
    int          laneRdCount;
    int          validCount;
    int          readyMode;
    int          readyPhase;
    int          permAuto;
    int          permDelay;
    int          permWait;
    int          checkAfterPerm;
    int          initPerm;
    logic        monStalled;
    logic [63:0] stallData;
    logic [7:0]  stallKeep;
    logic [63:0] gotData[$];
    logic [7:0]  gotKeep[$];
    logic        gotLast[$];
    vec_t        vecs[9];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] rate, input logic [15:0] nbytes);
        i_rate   = rate;
        i_nbytes = nbytes;
        i_start  = 1'b1;
        stepCycle();
        i_start  = 1'b0;
    endtask

    task automatic clearCounts();
        permCount   = 0;
        doneCount   = 0;
        laneRdCount = 0;
        validCount  = 0;
        gotData.delete();
        gotKeep.delete();
        gotLast.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},  64'(o_busy), 64'd0);
        checkOutput({tag, "_rd"},    64'(o_lane_rd), 64'd0);
        checkOutput({tag, "_addr"},  64'(o_lane_addr), 64'd0);
        checkOutput({tag, "_perm"},  64'(o_perm_start), 64'd0);
        checkOutput({tag, "_done"},  64'(o_done), 64'd0);
        checkOutput({tag, "_valid"}, 64'(sqz.o_valid), 64'd0);
        checkOutput({tag, "_data"},  sqz.o_data, 64'd0);
        checkOutput({tag, "_keep"},  64'(sqz.o_keep), 64'd0);
        checkOutput({tag, "_last"},  64'(sqz.o_last), 64'd0);
    endtask

    // Runs one table entry to completion and compares every emitted word.
    task automatic runVector(input vec_t v, input int idx);
        logic [63:0] ed;
        logic [7:0]  ek;
        int          byteSum;
        int          expPerms;
        clearCounts();
        readyMode = v.readyMode;
        permDelay = v.permDelay;
        permAuto  = 1;
        applyStimulus(v.rate, v.nbytes);
        for (int cyc = 0; cyc < 3000 && doneCount == 0; cyc++) begin
            if (v.midStart != 0 && cyc == 4) begin
                i_start  = 1'b1;
                i_nbytes = 16'd999;
            end else begin
                i_start  = 1'b0;
                i_nbytes = v.nbytes;
            end
            stepCycle();
        end
        i_start = 1'b0;
        stepCycle();
        stepCycle();
        expPerms = v.expPerms + initPerm;
        checkOutput($sformatf("v%0d_done", idx),  64'(doneCount), 64'd1);
        checkOutput($sformatf("v%0d_idle", idx),  64'(o_busy), 64'd0);
        checkOutput($sformatf("v%0d_words", idx), 64'(gotData.size()), 64'(v.expWords));
        checkOutput($sformatf("v%0d_perms", idx), 64'(permCount), 64'(expPerms));
        byteSum = 0;
        foreach (gotKeep[i]) byteSum += $countones(gotKeep[i]);
        checkOutput($sformatf("v%0d_bytes", idx), 64'(byteSum), 64'(v.nbytes));
        for (int w = 0; w < gotData.size() && w < v.expWords; w++) begin
            ek = (w == v.expWords - 1) ? v.expLastKeep : 8'hFF;
            ed = '0;
            for (int k = 0; k < 8; k++) begin
                if (ek[k]) ed[63-8*k -: 8] = 8'(8 * (w % v.effRate) + k);
            end
            checkOutput($sformatf("v%0d_w%0d_data", idx, w), gotData[w], ed);
            checkOutput($sformatf("v%0d_w%0d_keep", idx, w), 64'(gotKeep[w]), 64'(ek));
            checkOutput($sformatf("v%0d_w%0d_last", idx, w), 64'(gotLast[w]), 64'(w == v.expWords - 1));
        end
    endtask

    // Lane register file model: read data appears one cycle after the strobe.
    always @(posedge i_clk) begin
        if (o_lane_rd) begin
            i_lane_data <= 64'h0706050403020100 + 64'(o_lane_addr) * 64'h0808080808080808;
        end
    end

    // Consumer ready pattern: always, one cycle in three, or never.
    initial begin
        sqz.i_ready = 1'b0;
        readyPhase  = 0;
        forever begin
            @(posedge i_clk);
            #1;
            case (readyMode)
                0:       sqz.i_ready = 1'b1;
                1:       sqz.i_ready = (readyPhase == 0);
                default: sqz.i_ready = 1'b0;
            endcase
            readyPhase = (readyPhase == 2) ? 0 : readyPhase + 1;
        end
    end

    // Permutation responder: answers a request after permDelay cycles and then
    // expects a read of lane 0 on the very next cycle.
    initial begin
        permWait       = -1;
        checkAfterPerm = 0;
        forever begin
            @(posedge i_clk);
            #1;
            if (permAuto != 0) begin
                if (checkAfterPerm != 0) begin
                    checkOutput("rdAfterPerm", 64'(o_lane_rd), 64'd1);
                    checkOutput("addrAfterPerm", 64'(o_lane_addr), 64'd0);
                    checkAfterPerm = 0;
                end
                i_perm_done = 1'b0;
                if (o_perm_start) permWait = permDelay;
                else if (permWait > 0) permWait--;
                if (permWait == 0) begin
                    i_perm_done    = 1'b1;
                    checkAfterPerm = 1;
                    permWait       = -1;
                end
            end else begin
                permWait       = -1;
                checkAfterPerm = 0;
            end
        end
    end

    // Stream monitor: records handshakes, counts pulses, and checks hold-while-stalled.
    always @(negedge i_clk) begin
        if (sqz.o_valid && monStalled) begin
            checkOutput("stallData", sqz.o_data, stallData);
            checkOutput("stallKeep", 64'(sqz.o_keep), 64'(stallKeep));
        end
        if (sqz.o_valid === 1'b1 && sqz.i_ready === 1'b1) begin
            gotData.push_back(sqz.o_data);
            gotKeep.push_back(sqz.o_keep);
            gotLast.push_back(sqz.o_last);
        end
        if (o_perm_start === 1'b1) permCount++;
        if (o_done === 1'b1)       doneCount++;
        if (o_lane_rd === 1'b1)    laneRdCount++;
        if (sqz.o_valid === 1'b1)  validCount++;
        monStalled = (sqz.o_valid === 1'b1) && (sqz.i_ready !== 1'b1);
        stallData  = sqz.o_data;
        stallKeep  = sqz.o_keep;
    end

    initial begin
        errCount    = 0;
        checkCount  = 0;
        readyMode   = 0;
        permAuto    = 0;
        permDelay   = 5;
        monStalled  = 1'b0;
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_rate      = 5'd0;
        i_nbytes    = 16'd0;
        i_perm_done = 1'b0;
`ifdef KECCAK_SQZ_INITPERM_EN
        initPerm = 1;
`else
        initPerm = 0;
`endif
        //           rate   nbytes  rdy dly mid eff words perms lastKeep
        vecs[0] = '{5'd21, 16'd32,  0,  5,  1,  21, 4,    0,    8'hFF};
        vecs[1] = '{5'd21, 16'd170, 0,  5,  0,  21, 22,   1,    8'h03};
        vecs[2] = '{5'd21, 16'd13,  1,  5,  0,  21, 2,    0,    8'h1F};
        vecs[3] = '{5'd17, 16'd200, 0,  3,  0,  17, 25,   1,    8'hFF};
        vecs[4] = '{5'd9,  16'd75,  1,  0,  0,  9,  10,   1,    8'h07};
        vecs[5] = '{5'd0,  16'd5,   0,  5,  0,  21, 1,    0,    8'h1F};
        vecs[6] = '{5'd30, 16'd176, 0,  2,  0,  21, 22,   1,    8'hFF};
        vecs[7] = '{5'd21, 16'd168, 0,  5,  0,  21, 21,   0,    8'hFF};
        vecs[8] = '{5'd1,  16'd20,  0,  0,  0,  1,  3,    2,    8'h0F};

        repeat (3) stepCycle();
        checkAllZero("reset");
        i_rst = 1'b0;
        stepCycle();

`ifndef KECCAK_SQZ_INITPERM_EN
        // Minimum-latency single word: read at 1, capture at 2, valid at 3, done at 4.
        clearCounts();
        readyMode = 0;
        applyStimulus(5'd21, 16'd8);
        checkOutput("t1_rd",    64'(o_lane_rd), 64'd1);
        checkOutput("t1_addr",  64'(o_lane_addr), 64'd0);
        checkOutput("t1_busy",  64'(o_busy), 64'd1);
        stepCycle();
        checkOutput("t2_rd",    64'(o_lane_rd), 64'd0);
        checkOutput("t2_valid", 64'(sqz.o_valid), 64'd0);
        stepCycle();
        checkOutput("t3_valid", 64'(sqz.o_valid), 64'd1);
        checkOutput("t3_data",  sqz.o_data, 64'h0001020304050607);
        checkOutput("t3_keep",  64'(sqz.o_keep), 64'hFF);
        checkOutput("t3_last",  64'(sqz.o_last), 64'd1);
        stepCycle();
        checkOutput("t4_valid", 64'(sqz.o_valid), 64'd0);
        checkOutput("t4_done",  64'(o_done), 64'd1);
        stepCycle();
        checkOutput("t5_busy",  64'(o_busy), 64'd0);
        checkOutput("t5_done",  64'(o_done), 64'd0);
        stepCycle();
`else
        // Initial permutation comes first, then the lane read after it completes.
        clearCounts();
        readyMode = 0;
        permAuto  = 0;
        applyStimulus(5'd21, 16'd8);
        checkOutput("ip1_perm", 64'(o_perm_start), 64'd1);
        checkOutput("ip1_rd",   64'(o_lane_rd), 64'd0);
        stepCycle();
        checkOutput("ip2_perm", 64'(o_perm_start), 64'd0);
        checkOutput("ip2_busy", 64'(o_busy), 64'd1);
        i_perm_done = 1'b1;
        stepCycle();
        i_perm_done = 1'b0;
        checkOutput("ip3_rd",   64'(o_lane_rd), 64'd1);
        checkOutput("ip3_addr", 64'(o_lane_addr), 64'd0);
        for (int c = 0; c < 20 && doneCount == 0; c++) stepCycle();
        stepCycle();
        checkOutput("ip_words", 64'(gotData.size()), 64'd1);
        if (gotLast.size() > 0) checkOutput("ip_last", 64'(gotLast[0]), 64'd1);
        checkOutput("ip_done",  64'(doneCount), 64'd1);
`endif

        for (int i = 0; i < 9; i++) begin
            runVector(vecs[i], i);
        end

        // Empty squeeze: finishes without reading, streaming or permuting.
        clearCounts();
        permAuto = 1;
        applyStimulus(5'd21, 16'd0);
        repeat (3) stepCycle();
        checkOutput("z_done",  64'(doneCount), 64'd1);
        checkOutput("z_rd",    64'(laneRdCount), 64'd0);
        checkOutput("z_valid", 64'(validCount), 64'd0);
        checkOutput("z_perm",  64'(permCount), 64'd0);
        checkOutput("z_busy",  64'(o_busy), 64'd0);

        // Reset while waiting in PERM; a late permutation completion must be ignored.
        clearCounts();
        permAuto    = 0;
        i_perm_done = 1'b0;
        applyStimulus(5'd1, 16'd20);
        for (int c = 0; c < 50 && !o_perm_start; c++) stepCycle();
        checkOutput("rp_reached", 64'(o_perm_start), 64'd1);
        stepCycle();
        i_rst = 1'b1;
        stepCycle();
        i_rst = 1'b0;
        checkAllZero("rstPerm");
        clearCounts();
        i_perm_done = 1'b1;
        stepCycle();
        i_perm_done = 1'b0;
        repeat (3) stepCycle();
        checkOutput("rp_rd",    64'(laneRdCount), 64'd0);
        checkOutput("rp_valid", 64'(validCount), 64'd0);
        checkOutput("rp_done",  64'(doneCount), 64'd0);
        checkOutput("rp_perm",  64'(permCount), 64'd0);
        checkOutput("rp_busy",  64'(o_busy), 64'd0);

        // Reset while a word is held in OUT with the consumer stalled.
        clearCounts();
        readyMode = 2;
        permAuto  = 1;
        permDelay = 2;
        applyStimulus(5'd21, 16'd16);
        for (int c = 0; c < 50 && !sqz.o_valid; c++) stepCycle();
        checkOutput("ro_valid", 64'(sqz.o_valid), 64'd1);
        checkOutput("ro_data",  sqz.o_data, 64'h0001020304050607);
        stepCycle();
        i_rst = 1'b1;
        stepCycle();
        i_rst = 1'b0;
        checkAllZero("rstOut");
        readyMode = 0;
        stepCycle();

        // A fresh start after the resets behaves normally.
        runVector(vecs[2], 90);
        runVector(vecs[1], 91);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
